hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_if.sv | 39 +++
 rtl/hazard_forward_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/hazard_forward_unit_if.sv
// Operand-resolution bus between the ID stage and the hazard/forwarding unit.
// The pipeline drives through the master modport; the unit uses the slave modport.
interface hazard_forward_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_RD*REG_AW-1:0] rd_num;
    logic [NUM_RD-1:0]        rd_used;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     ex_wen;
    logic                     ex_is_load;
    logic [REG_AW-1:0]        ex_wnum;
    logic [DATA_W-1:0]        ex_data;
    logic                     mem_wen;
    logic [REG_AW-1:0]        mem_wnum;
    logic [DATA_W-1:0]        mem_data;
    logic                     flush;
    logic                     stall;
    logic [NUM_RD*DATA_W-1:0] fwd_data;
    logic [NUM_RD*2-1:0]      fwd_sel;
    logic [CNT_W-1:0]         stall_events;
    logic [CNT_W-1:0]         stall_cycles;

    modport master (
        output rd_num, rd_used, rd_data,
        output ex_wen, ex_is_load, ex_wnum, ex_data,
        output mem_wen, mem_wnum, mem_data, flush,
        input  stall, fwd_data, fwd_sel, stall_events, stall_cycles
    );

    modport slave (
        input  rd_num, rd_used, rd_data,
        input  ex_wen, ex_is_load, ex_wnum, ex_data,
        input  mem_wen, mem_wnum, mem_data, flush,
        output stall, fwd_data, fwd_sel, stall_events, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall control and EX/MEM operand forwarding for the ID stage,
// with saturating stall performance counters.
module hazard_forward_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_RD     = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_unit_if.slave bus
);
    localparam int CW = $clog2(LOAD_STALL) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic [NUM_RD-1:0]        ex_match;
    logic [NUM_RD-1:0]        mem_match;
    logic                     hazard;
    logic                     stall;
    logic [NUM_RD*DATA_W-1:0] fwd_data_reg, fwd_data_next;
    logic [NUM_RD*2-1:0]      fwd_sel_reg, fwd_sel_next;
    logic [CNT_W-1:0]         events_reg, cycles_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [REG_AW-1:0] num;
            logic              live;
            logic              ex_fwd;
            assign num  = bus.rd_num[gi*REG_AW +: REG_AW];
            // r0 is hard-wired zero, so it never participates in a hazard
            assign live = bus.rd_used[gi] && (num != '0);
            assign ex_match[gi]  = live && bus.ex_wen  && (bus.ex_wnum  == num);
            assign mem_match[gi] = live && bus.mem_wen && (bus.mem_wnum == num);
            // A load in EX has no data yet; it can only be covered by a stall
            assign ex_fwd = ex_match[gi] && !bus.ex_is_load;
            assign fwd_data_next[gi*DATA_W +: DATA_W] =
                ex_fwd        ? bus.ex_data  :
                mem_match[gi] ? bus.mem_data :
                                bus.rd_data[gi*DATA_W +: DATA_W];
            assign fwd_sel_next[gi*2 +: 2] =
                ex_fwd        ? 2'd1 :
                mem_match[gi] ? 2'd2 :
                                2'd0;
        end
    endgenerate

    assign hazard = bus.ex_is_load && (|ex_match);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = hazard && !bus.flush;
                if (stall && (LOAD_STALL > 1)) begin
                    state_next = STALL;
                    cnt_next   = CW'(LOAD_STALL - 1);
                end
            end
            STALL: begin
                stall    = !bus.flush;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            fwd_data_reg <= '0;
            fwd_sel_reg  <= '0;
            events_reg   <= '0;
            cycles_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (!stall) begin
                fwd_data_reg <= fwd_data_next;
                fwd_sel_reg  <= fwd_sel_next;
            end
            // An event is counted only when a stall begins from IDLE
            if (stall && (state_reg == IDLE) && (events_reg != '1)) begin
                events_reg <= events_reg + CNT_W'(1);
            end
            if (stall && (cycles_reg != '1)) begin
                cycles_reg <= cycles_reg + CNT_W'(1);
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.fwd_data     = fwd_data_reg;
    assign bus.fwd_sel      = fwd_sel_reg;
    assign bus.stall_events = events_reg;
    assign bus.stall_cycles = cycles_reg;
endmodule
